// File: rtl/crop_pkg.sv
// Shared types for the ROI crop engine: FSM states, coordinate/address types
// and the row padding helper.
package crop_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    RD    = 3'd2,
    WAIT  = 3'd3,
    WR    = 3'd4,
    PAD   = 3'd5,
    DONE  = 3'd6
  } state_t;

  typedef logic [10:0] coord_t;
  typedef logic [23:0] addr_t;

  // Zero bytes needed to round one output row up to a 4-byte boundary.
  function automatic logic [1:0] pad_bytes(input coord_t w, input int unsigned channels);
    int unsigned bytes;
    bytes = 32'(w) * channels;
    return 2'((32'd4 - (bytes % 32'd4)) % 32'd4);
  endfunction

endpackage

// File: rtl/crop_addr_gen.sv
// Source byte address for pixel (x, y), channel ch, in a row-major
// interleaved image; all arithmetic is carried at the full 24-bit width.
module crop_addr_gen
  import crop_pkg::*;
#(
  parameter int WIDTH    = 100,
  parameter int CHANNELS = 3
) (
  input  logic [10:0] y,
  input  logic [10:0] x,
  input  logic [1:0]  ch,
  output logic [23:0] addr
);

  localparam addr_t ROW_BYTES = addr_t'(WIDTH * CHANNELS);
  localparam addr_t PIX_BYTES = addr_t'(CHANNELS);

  assign addr = addr_t'(y) * ROW_BYTES + addr_t'(x) * PIX_BYTES + addr_t'(ch);

endmodule

// File: rtl/roi_crop_engine.sv
// Copies a rectangular region of a source image to a padded destination,
// bottom row first. Define CROP_MIRROR_EN to add the horizontal mirror input.
module roi_crop_engine
  import crop_pkg::*;
#(
  parameter int WIDTH     = 100,
  parameter int HEIGHT    = 100,
  parameter int CHANNELS  = 3,
  parameter int HDR_BYTES = 54,
  parameter int RD_LAT    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
`ifdef CROP_MIRROR_EN
  input  logic        mirror,
`endif
  input  logic [10:0] x_min,
  input  logic [10:0] x_max,
  input  logic [10:0] y_min,
  input  logic [10:0] y_max,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [23:0] rd_addr,
  input  logic [15:0] rd_data,
  output logic [23:0] wr_addr,
  output logic [15:0] wr_data,
  output logic        wren,
  output logic [2:0]  dbg_state
);

  state_t state_q, state_d;
  coord_t x_lo, x_hi, y_lo, y_hi, x_q, y_q;
  logic [1:0] ch_q, pad_q, pad_cnt, wait_cnt;
  addr_t  wr_addr_q;
  logic   err_q, mir_q;
  logic   accept, bad_bounds, last_ch, last_x, last_y, last_pad, row_end, wait_end;
  coord_t x_first, x_end;

  assign accept     = start && (state_q == IDLE || state_q == DONE);
  assign bad_bounds = (x_lo > x_hi) || (y_lo > y_hi) ||
                      (int'(x_hi) >= WIDTH) || (int'(y_hi) >= HEIGHT);
  assign x_first    = mir_q ? x_hi : x_lo;
  assign x_end      = mir_q ? x_lo : x_hi;
  assign last_ch    = (ch_q == 2'(CHANNELS - 1));
  assign last_x     = (x_q == x_end);
  assign last_y     = (y_q == y_lo);
  assign last_pad   = (pad_cnt == 2'd1);
  assign row_end    = last_ch && last_x;
  assign wait_end   = (wait_cnt == 2'(RD_LAT - 2));

`ifdef CROP_MIRROR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      mir_q <= 1'b0;
    else if (accept) mir_q <= mirror;
  end
`else
  assign mir_q = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = CHECK;
      CHECK:      state_d = bad_bounds ? DONE : RD;
      RD:         state_d = (RD_LAT == 1) ? WR : WAIT;
      WAIT:       if (wait_end) state_d = WR;
      WR: begin
        if (!row_end)          state_d = RD;
        else if (pad_q != 2'd0) state_d = PAD;
        else                   state_d = last_y ? DONE : RD;
      end
      PAD:        if (last_pad) state_d = last_y ? DONE : RD;
      default:    state_d = IDLE;
    endcase
  end

  // Scan counters only move at the end of a write, so rd_addr is stable
  // from RD through WR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_lo <= '0; x_hi <= '0; y_lo <= '0; y_hi <= '0;
      x_q <= '0; y_q <= '0; ch_q <= '0;
      pad_q <= '0; pad_cnt <= '0; wait_cnt <= '0;
      err_q <= 1'b0;
      wr_addr_q <= addr_t'(HDR_BYTES);
    end else begin
      if (accept) begin
        x_lo <= x_min; x_hi <= x_max; y_lo <= y_min; y_hi <= y_max;
        err_q <= 1'b0;
        wr_addr_q <= addr_t'(HDR_BYTES);
      end
      case (state_q)
        CHECK: begin
          err_q <= bad_bounds;
          if (!bad_bounds) begin
            x_q   <= x_first;
            y_q   <= y_hi;
            ch_q  <= '0;
            pad_q <= pad_bytes(x_hi - x_lo + 11'd1, CHANNELS);
          end
        end
        RD:   wait_cnt <= '0;
        WAIT: wait_cnt <= wait_cnt + 2'd1;
        WR: begin
          wr_addr_q <= wr_addr_q + 24'd1;
          if (!last_ch) ch_q <= ch_q + 2'd1;
          else begin
            ch_q <= '0;
            if (!last_x)             x_q <= mir_q ? x_q - 11'd1 : x_q + 11'd1;
            else if (pad_q != 2'd0) pad_cnt <= pad_q;
            else if (!last_y) begin
              y_q <= y_q - 11'd1;
              x_q <= x_first;
            end
          end
        end
        PAD: begin
          wr_addr_q <= wr_addr_q + 24'd1;
          pad_cnt   <= pad_cnt - 2'd1;
          if (last_pad && !last_y) begin
            y_q <= y_q - 11'd1;
            x_q <= x_first;
          end
        end
        default: ;
      endcase
    end
  end

  crop_addr_gen #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) u_addr_gen (
    .y(y_q), .x(x_q), .ch(ch_q), .addr(rd_addr)
  );

  always_comb begin
    busy      = (state_q != IDLE) && (state_q != DONE);
    done      = (state_q == DONE);
    err       = err_q && (state_q == DONE);
    wren      = (state_q == WR) || (state_q == PAD);
    wr_data   = (state_q == WR) ? rd_data : 16'h0000;
    wr_addr   = wr_addr_q;
    dbg_state = state_q;
  end

endmodule

// File: doc/roi_crop_engine.md
ROI_CROP_ENGINE -- requirements
Module: roi_crop_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 100, meaning source image width in pixels.
REQ-002 SHALL have parameter HEIGHT, default 100, meaning source image height in pixels.
REQ-003 SHALL have parameter CHANNELS, default 3, meaning bytes per pixel (legal 1..4).
REQ-004 SHALL have parameter HDR_BYTES, default 54, meaning first destination address (header space).
REQ-005 SHALL have parameter RD_LAT, default 1, meaning read latency in cycles from rd_addr to valid rd_data (legal 1..4).
REQ-006 clk  input  1  sole clock; all state changes on its rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 start  input  1  request a crop; sampled in IDLE and DONE only.
REQ-009 x_min, x_max, y_min, y_max  input  11 each  inclusive crop bounds, latched on accepted start.
REQ-010 busy  output  1  high from accepted start until DONE is entered.
REQ-011 done  output  1  high while in DONE.
REQ-012 err  output  1  high in DONE when the latched bounds were rejected.
REQ-013 rd_addr  output  24  source byte address; rd_data  input  16  source data (low byte significant).
REQ-014 wr_addr  output  24  destination address; wr_data  output  16  write data; wren  output  1  write strobe.

Function
REQ-015 States SHALL be IDLE, CHECK, RD, WAIT, WR, PAD, DONE.
REQ-016 IDLE/DONE + start: latch bounds, wr_addr <= HDR_BYTES, go CHECK; start elsewhere SHALL be ignored.
REQ-017 CHECK: if x_min>x_max, y_min>y_max, x_max>=WIDTH or y_max>=HEIGHT, go DONE with err=1 and zero writes; else err=0, x=x_min, y=y_max, ch=0, go RD.
REQ-018 rd_addr SHALL equal y*WIDTH*CHANNELS + x*CHANNELS + ch, computed at 24 bits without truncation of intermediates.
REQ-019 RD lasts 1 cycle, WAIT RD_LAT-1 cycles (skipped when RD_LAT=1), then WR; rd_addr SHALL stay constant RD through WR.
REQ-020 WR: wren=1 for exactly one cycle, wr_data=rd_data, then wr_addr increments by 1.
REQ-021 Scan order: ch 0..CHANNELS-1, then x ascending to x_max inclusive, then y descending to y_min inclusive (no unsigned underflow at y=0).
REQ-022 After last byte of each row, PAD SHALL write P=(4-(w*CHANNELS mod 4)) mod 4 zero bytes, w=x_max-x_min+1, one per cycle with wren=1, wr_data=0; P=0 skips PAD.
REQ-023 After the final row (and its padding) go DONE; total writes SHALL equal h*(w*CHANNELS+P), h=y_max-y_min+1.
REQ-024 Outputs SHALL be registered or decoded from state only; wren SHALL be 0 outside WR and PAD.
REQ-025 Bound inputs changing while busy SHALL have no effect.

Reset
REQ-026 rst_n low SHALL immediately force IDLE, busy=0, done=0, err=0, wren=0, wr_data=0, rd_addr=0, wr_addr=HDR_BYTES, regardless of state; in-flight crop is abandoned.
REQ-027 First accepted start after reset deassertion SHALL behave as a fresh crop.

Configuration
REQ-028 With CROP_MIRROR_EN defined, an input mirror (1 bit, latched with bounds) SHALL make x scan x_max down to x_min per row; channel order and padding unchanged.
REQ-029 Without CROP_MIRROR_EN, the mirror port SHALL be absent and x SHALL always ascend.

Structure
REQ-030 Package crop_pkg SHALL hold the state enum, coord_t (11-bit), addr_t (24-bit) and a pad_bytes(w, channels) function.
REQ-031 Sub-module crop_addr_gen SHALL compute rd_addr from (y, x, ch) combinationally; FSM stays in roi_crop_engine.

Verification
REQ-032 Defaults, bounds x 0..3, y 0..1 -> 24 writes, no PAD, wr_addr 54..77, rows y=1 then y=0, done=1 err=0.
REQ-033 Bounds x 2..2, y 5..5, CHANNELS=3 -> 3 data writes + 1 zero pad, rd_addr 1506..1508.
REQ-034 x_min=10, x_max=4 -> DONE within 2 cycles of start, err=1, wren never asserted.
REQ-035 RD_LAT=3, single pixel -> each wren exactly 3 cycles after its rd_addr first appears.
REQ-036 rst_n low mid-row -> wren 0 same cycle, IDLE; next start restarts at wr_addr 54.
REQ-037 CROP_MIRROR_EN, mirror=1, x 0..1, y 0..0 -> rd_addr order 3,4,5,0,1,2 then 2 pad bytes.
